// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM state encoding and
// the default program-length limit.
package loader_pkg;

    localparam int DEFAULT_MAX_WORDS = 256;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        W_HI,
        W_LO,
        WRITE,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Joins a high byte and a following low byte into a 16-bit word.
// pair is combinational so the caller can act on it during the low-byte transfer.
module word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [7:0]  byte_in,
    output logic [15:0] pair,
    output logic [15:0] word
);

    logic [7:0] hi_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            hi_q <= '0;
        end else if (hi_we) begin
            hi_q <= byte_in;
        end
    end

    // word only moves on a committed low byte, so it holds between strobes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word <= '0;
        end else if (lo_we) begin
            word <= {hi_q, byte_in};
        end
    end

    assign pair = {hi_q, byte_in};

endmodule

// File: rtl/instr_loader.sv
// Serial program loader: takes a length-prefixed byte stream and writes
// 16-bit instruction words into CPU instruction memory while holding the CPU.
module instr_loader
    import loader_pkg::*;
#(
    parameter int MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] instruction_in,
    output logic [15:0] load_address,
    output logic        load_instruction,
    output logic        pc_reset,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic [15:0] pair;
    logic [15:0] count_q;
    logic [15:0] addr_q;
    logic [15:0] addr_inc;
    logic        hi_we;
    logic        lo_we;
    logic        count_we;
    logic        addr_clr;
    logic        addr_step;

    word_assembler u_word_assembler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (addr_clr),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .byte_in (byte_in),
        .pair    (pair),
        .word    (instruction_in)
    );

    assign addr_inc     = addr_q + 16'd1;
    assign load_address = addr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        byte_ready       = 1'b0;
        load_instruction = 1'b0;
        pc_reset         = 1'b1;
        done             = 1'b0;
        error            = 1'b0;
        hi_we            = 1'b0;
        lo_we            = 1'b0;
        count_we         = 1'b0;
        addr_clr         = 1'b0;
        addr_step        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LEN_HI;
                    addr_clr   = 1'b1;
                end
            end
            LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    hi_we      = 1'b1;
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    count_we = 1'b1;
                    // decide on the assembled length in the same cycle it arrives
                    if (pair == 16'd0) begin
                        state_next = DONE;
                    end else if ({1'b0, pair} > MAX_LEN) begin
                        state_next = ERR;
                    end else begin
                        state_next = W_HI;
                    end
                end
            end
            W_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    hi_we      = 1'b1;
                    state_next = W_LO;
                end
            end
            W_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    lo_we      = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                load_instruction = 1'b1;
                addr_step        = 1'b1;
                state_next       = (addr_inc == count_q) ? DONE : W_HI;
            end
            DONE: begin
                pc_reset = 1'b0;
                done     = 1'b1;
                if (start) begin
                    state_next = LEN_HI;
                    addr_clr   = 1'b1;
                end
            end
            ERR: begin
                error = 1'b1;
                if (start) begin
                    state_next = LEN_HI;
                    addr_clr   = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // count never exceeds MAX_WORDS on the write path, so addr_q cannot wrap
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            addr_q  <= '0;
        end else begin
            if (addr_clr) begin
                addr_q <= '0;
            end else if (addr_step) begin
                addr_q <= addr_inc;
            end
            if (count_we) begin
                count_q <= pair;
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: normal loads, empty and oversize lengths,
// stalled byte stream, mid-load reset and stray start pulses.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] instruction_in;
    logic [15:0] load_address;
    logic        load_instruction;
    logic        pc_reset;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    logic [15:0] s_addr[$];
    logic [15:0] s_data[$];

    always #5 clk = ~clk;

    instr_loader #(.MAX_WORDS(256)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .byte_in          (byte_in),
        .byte_valid       (byte_valid),
        .byte_ready       (byte_ready),
        .instruction_in   (instruction_in),
        .load_address     (load_address),
        .load_instruction (load_instruction),
        .pc_reset         (pc_reset),
        .done             (done),
        .error            (error)
    );

    always @(negedge clk) begin
        if (load_instruction) begin
            s_addr.push_back(load_address);
            s_data.push_back(instruction_in);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        int   n;
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) tick();
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        do begin
            rdy = byte_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        byte_valid = 1'b0;
        chk1("byte_accept", rdy, 1'b1);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        send_byte(w[15:8], gap);
        send_byte(w[7:0], gap);
    endtask

    task automatic chk_strobe(input string tag, input int idx, input logic [15:0] a, input logic [15:0] d);
        if (idx < s_addr.size()) begin
            chk({tag, "_addr"}, s_addr[idx], a);
            chk({tag, "_data"}, s_data[idx], d);
        end else begin
            total++;
            bad++;
            $error("FAIL %s: observed=no strobe %0d expected=strobe", tag, idx);
        end
    endtask

    task automatic clear_q();
        s_addr.delete();
        s_data.delete();
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (2) tick();

        // reset state
        chk1("rst_pc_reset", pc_reset, 1'b1);
        chk1("rst_done", done, 1'b0);
        chk1("rst_error", error, 1'b0);
        chk1("rst_byte_ready", byte_ready, 1'b0);
        chk1("rst_load_instr", load_instruction, 1'b0);
        chk("rst_addr", load_address, 16'h0000);
        chk("rst_instr", instruction_in, 16'h0000);
        reset_n = 1'b1;
        tick();
        chk1("idle_byte_ready", byte_ready, 1'b0);

        // two-word load: 00 02 12 34 AB CD
        clear_q();
        pulse_start();
        chk1("lenhi_ready", byte_ready, 1'b1);
        chk1("lenhi_pc_reset", pc_reset, 1'b1);
        send_word(16'h0002, 0);
        send_word(16'h1234, 0);
        chk1("w0_strobe", load_instruction, 1'b1);
        chk("w0_addr", load_address, 16'h0000);
        chk("w0_data", instruction_in, 16'h1234);
        chk1("w0_not_done", done, 1'b0);
        send_word(16'hABCD, 0);
        chk1("w1_strobe", load_instruction, 1'b1);
        chk("w1_addr", load_address, 16'h0001);
        chk("w1_data", instruction_in, 16'hABCD);
        tick();
        chk1("ld2_done", done, 1'b1);
        chk1("ld2_pc_reset", pc_reset, 1'b0);
        chk1("ld2_no_strobe", load_instruction, 1'b0);
        chk("ld2_hold_data", instruction_in, 16'hABCD);
        chk("ld2_addr", load_address, 16'h0002);
        chk("ld2_nstrobe", 16'(s_addr.size()), 16'd2);
        chk_strobe("ld2_s0", 0, 16'h0000, 16'h1234);
        chk_strobe("ld2_s1", 1, 16'h0001, 16'hABCD);

        // empty program
        clear_q();
        pulse_start();
        chk("empty_addr_clr", load_address, 16'h0000);
        send_word(16'h0000, 0);
        chk1("empty_done", done, 1'b1);
        chk1("empty_pc_reset", pc_reset, 1'b0);
        chk1("empty_ready", byte_ready, 1'b0);
        tick();
        chk("empty_nstrobe", 16'(s_addr.size()), 16'd0);

        // oversize length, then recovery
        pulse_start();
        send_word(16'h0101, 0);
        chk1("err_error", error, 1'b1);
        chk1("err_pc_reset", pc_reset, 1'b1);
        chk1("err_ready", byte_ready, 1'b0);
        chk1("err_done", done, 1'b0);
        tick();
        chk1("err_stays", error, 1'b1);
        chk("err_nstrobe", 16'(s_addr.size()), 16'd0);
        pulse_start();
        chk1("err_clear", error, 1'b0);
        send_word(16'h0001, 0);
        send_word(16'hBEEF, 0);
        chk1("rec_strobe", load_instruction, 1'b1);
        tick();
        chk1("rec_done", done, 1'b1);
        chk("rec_nstrobe", 16'(s_addr.size()), 16'd1);
        chk_strobe("rec_s0", 0, 16'h0000, 16'hBEEF);

        // maximum length accepted, last address MAX_WORDS-1
        clear_q();
        pulse_start();
        send_word(16'h0100, 0);
        chk1("max_accepted", error, 1'b0);
        for (int i = 0; i < 256; i++) begin
            send_word({i[7:0], ~i[7:0]}, 0);
        end
        chk("max_last_addr", load_address, 16'h00FF);
        tick();
        chk1("max_done", done, 1'b1);
        chk("max_nstrobe", 16'(s_addr.size()), 16'd256);
        for (int i = 0; i < 256; i++) begin
            chk_strobe("max_s", i, 16'(i), {i[7:0], ~i[7:0]});
        end

        // stalled byte stream
        clear_q();
        pulse_start();
        send_word(16'h0003, int'($urandom_range(3, 0)));
        send_word(16'h1122, int'($urandom_range(3, 0)));
        send_word(16'h3344, int'($urandom_range(3, 0)));
        send_word(16'h5566, int'($urandom_range(3, 0)));
        tick();
        chk1("stall_done", done, 1'b1);
        chk("stall_nstrobe", 16'(s_addr.size()), 16'd3);
        chk_strobe("stall_s0", 0, 16'h0000, 16'h1122);
        chk_strobe("stall_s1", 1, 16'h0001, 16'h3344);
        chk_strobe("stall_s2", 2, 16'h0002, 16'h5566);

        // reset after the high byte of the second word
        pulse_start();
        send_word(16'h0002, 0);
        send_word(16'h7788, 0);
        send_byte(8'h12, 0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        clear_q();
        chk1("mrst_pc_reset", pc_reset, 1'b1);
        chk1("mrst_ready", byte_ready, 1'b0);
        chk1("mrst_done", done, 1'b0);
        chk("mrst_addr", load_address, 16'h0000);
        chk("mrst_instr", instruction_in, 16'h0000);
        byte_in    = 8'h34;
        byte_valid = 1'b1;
        repeat (5) tick();
        byte_valid = 1'b0;
        chk("mrst_nstrobe", 16'(s_addr.size()), 16'd0);
        pulse_start();
        send_word(16'h0001, 0);
        send_word(16'h5678, 0);
        chk1("mrst_reload_strobe", load_instruction, 1'b1);
        chk("mrst_reload_addr", load_address, 16'h0000);
        chk("mrst_reload_data", instruction_in, 16'h5678);
        tick();
        chk1("mrst_reload_done", done, 1'b1);

        // start pulse during W_HI is ignored
        clear_q();
        pulse_start();
        send_word(16'h0002, 0);
        pulse_start();
        chk1("stray_ready", byte_ready, 1'b1);
        chk("stray_addr", load_address, 16'h0000);
        send_word(16'h9ABC, 0);
        send_word(16'hDEF0, 0);
        tick();
        chk1("stray_done", done, 1'b1);
        chk("stray_nstrobe", 16'(s_addr.size()), 16'd2);
        chk_strobe("stray_s0", 0, 16'h0000, 16'h9ABC);
        chk_strobe("stray_s1", 1, 16'h0001, 16'hDEF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
